// File: rtl/pc_sequencer_if.sv
// Bundle between the decoder/datapath side (master) and the fetch PC stage (slave).
// Carries decode strobes, operand values and the PC/status/statistics outputs.
interface pc_sequencer_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
);
    logic [31:0]          Instr;
    logic                 Beq;
    logic                 Bne;
    logic                 BLTZ;
    logic                 JMP;
    logic                 JAL;
    logic                 JR;
    logic                 SysCALL;
    logic                 Equal;
    logic [31:0]          RsData;
    logic [31:0]          V0Data;
    logic [31:0]          A0Data;
    logic                 Go;
    logic [PC_WIDTH-1:0]  PC;
    logic [PC_WIDTH-1:0]  PCPlus4;
    logic                 Halted;
    logic [31:0]          LedData;
    logic [CNT_WIDTH-1:0] CycleCnt;
    logic [CNT_WIDTH-1:0] JumpCnt;
    logic [CNT_WIDTH-1:0] BranchCnt;

    modport master (
        output Instr, Beq, Bne, BLTZ, JMP, JAL, JR, SysCALL, Equal,
        output RsData, V0Data, A0Data, Go,
        input  PC, PCPlus4, Halted, LedData, CycleCnt, JumpCnt, BranchCnt
    );

    modport slave (
        input  Instr, Beq, Bne, BLTZ, JMP, JAL, JR, SysCALL, Equal,
        input  RsData, V0Data, A0Data, Go,
        output PC, PCPlus4, Halted, LedData, CycleCnt, JumpCnt, BranchCnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-side PC stage: next-PC select, syscall halt/resume FSM and display latch.
// Statistics counters exist only when PC_SEQUENCER_STATS_EN is defined; otherwise they read 0.
module pc_sequencer #(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  CNT_WIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    pc_sequencer_if.slave     bus
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [31:0] SYS_EXIT  = 32'd10;
    localparam logic [31:0] SYS_LED   = 32'd34;

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [31:0]         led_q;

    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] br_tgt;
    logic [PC_WIDTH-1:0] j_tgt;
    logic [PC_WIDTH-1:0] rs_tgt;
    logic [PC_WIDTH-1:0] next_pc;
    logic                taken;
    logic                jump;

    assign pc_plus4 = pc_q + PC_WIDTH'(4);
    assign br_tgt   = pc_plus4 + {{(PC_WIDTH-18){bus.Instr[15]}}, bus.Instr[15:0], 2'b00};
    assign rs_tgt   = PC_WIDTH'(bus.RsData);

    // Jump target keeps the region bits of PC+4 above the 28-bit jump field.
    generate
        if (PC_WIDTH > 28) begin : g_jtgt_region
            assign j_tgt = {pc_plus4[PC_WIDTH-1:28], bus.Instr[25:0], 2'b00};
        end else begin : g_jtgt_flat
            assign j_tgt = {bus.Instr[25:0], 2'b00};
        end
    endgenerate

    assign taken = (bus.Beq & bus.Equal) | (bus.Bne & ~bus.Equal) | (bus.BLTZ & bus.RsData[31]);
    assign jump  = bus.JMP | bus.JAL | bus.JR;

    always_comb begin
        next_pc = pc_plus4;
        if (bus.JR)
            next_pc = rs_tgt;
        else if (bus.JMP | bus.JAL)
            next_pc = j_tgt;
        else if (taken)
            next_pc = br_tgt;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            led_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    // A syscall always falls through to PC+4, even if a jump strobe is also up.
                    if (bus.SysCALL) begin
                        pc_q <= pc_plus4;
                        if (bus.V0Data == SYS_EXIT)
                            state_q <= HALT;
                        else if (bus.V0Data == SYS_LED)
                            led_q <= bus.A0Data;
                    end else begin
                        pc_q <= next_pc;
                    end
                end
                HALT: begin
                    if (bus.Go)
                        state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.PC      = pc_q;
    assign bus.PCPlus4 = pc_plus4;
    assign bus.Halted  = (state_q == HALT);
    assign bus.LedData = led_q;

`ifdef PC_SEQUENCER_STATS_EN
    logic [CNT_WIDTH-1:0] cycle_cnt_q;
    logic [CNT_WIDTH-1:0] jump_cnt_q;
    logic [CNT_WIDTH-1:0] branch_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cycle_cnt_q  <= '0;
            jump_cnt_q   <= '0;
            branch_cnt_q <= '0;
        end else if (state_q == RUN) begin
            cycle_cnt_q <= cycle_cnt_q + CNT_WIDTH'(1);
            if (!bus.SysCALL) begin
                if (jump)
                    jump_cnt_q <= jump_cnt_q + CNT_WIDTH'(1);
                else if (taken)
                    branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.CycleCnt  = cycle_cnt_q;
    assign bus.JumpCnt   = jump_cnt_q;
    assign bus.BranchCnt = branch_cnt_q;
`else
    assign bus.CycleCnt  = '0;
    assign bus.JumpCnt   = '0;
    assign bus.BranchCnt = '0;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-side PC stage of the single-cycle MIPS CPU.
- Holds the program counter and drives instruction-memory addressing, feeding the instruction decoder.
- Consumes that decoder's branch/jump/syscall strobes plus datapath comparison results to select next PC.
- Implements the syscall halt/resume state machine, the display latch and performance counters.

Parameters:
- PC_WIDTH, 32, program counter width in bits; must be >= 28.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_WIDTH, 32, width of each statistics counter.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- Instr  in  32  current instruction; [15:0] is the branch offset, [25:0] is the jump index.
- Beq  in  1  decoder strobe for BEQ.
- Bne  in  1  decoder strobe for BNE.
- BLTZ  in  1  decoder strobe for BLTZ.
- JMP  in  1  decoder strobe for J.
- JAL  in  1  decoder strobe for JAL.
- JR  in  1  decoder strobe for JR.
- SysCALL  in  1  decoder strobe for SYSCALL.
- Equal  in  1  ALU equality flag (R1 == R2).
- RsData  in  32  register-file R1 read data; used for the JR target and the BLTZ sign.
- V0Data  in  32  $v0 value, the syscall service code.
- A0Data  in  32  $a0 value, the syscall argument.
- Go  in  1  level-sensitive resume request.
- PC  out  PC_WIDTH  current PC, the instruction-memory address.
- PCPlus4  out  PC_WIDTH  PC+4, combinational; the JAL link value.
- Halted  out  1  high while in HALT.
- LedData  out  32  display latch.
- CycleCnt  out  CNT_WIDTH  total executed cycles (STATS_EN only).
- JumpCnt  out  CNT_WIDTH  unconditional jumps (STATS_EN only).
- BranchCnt  out  CNT_WIDTH  taken branches (STATS_EN only).

Behaviour:
- Reset (asynchronous, RST_N=0): PC=RESET_PC, state=RUN, Halted=0, LedData=0, all counters=0. Reset mid-halt or mid-count returns to these values immediately. Outputs remain stable until the first rising edge after RST_N deasserts.

Next-PC selection, combinational:
- BrTgt = PC+4 + (sext(Instr[15:0])<<2).
- JTgt = {PCPlus4[31:28], Instr[25:0], 2'b00}.
- Taken = (Beq&Equal) | (Bne&~Equal) | (BLTZ&RsData[31]).
- Priority, highest first:
  - JR -> RsData.
  - JMP|JAL -> JTgt.
  - Taken -> BrTgt.
  - else PC+4.
- Arithmetic wraps modulo 2^PC_WIDTH. PC bits [1:0] are loaded as computed; misalignment is not checked.

State machine, one transition per edge:
- RUN:
  - SysCALL & V0Data==10: PC<=PC+4, go to HALT. Halted rises the cycle after the syscall edge.
  - SysCALL & V0Data==34: LedData<=A0Data, PC<=PC+4, stay in RUN.
  - SysCALL with any other code: acts as a NOP (PC+4).
  - No SysCALL: PC<=NextPC. Go is ignored in RUN.
- HALT:
  - PC, LedData and all counters are frozen; every control input except Go is ignored.
  - Go=1 at an edge: go to RUN. The instruction at the held PC executes on the following edge.
  - Go held high continuously re-enters RUN but does not skip a halting syscall: each V0==10 syscall always costs at least one HALT cycle.
- Simultaneous SysCALL with a jump/branch strobe cannot arise from a legal decode; SysCALL wins (PC+4).

Latency:
- PC updates one edge after inputs settle.
- PCPlus4, NextPC and Halted have zero combinational latency from state.

Optional Feature:
- Macro PC_SEQUENCER_STATS_EN.
- Defined: counters are present. Each counter increments by 1 at an edge only in RUN and never when RST_N=0. Each wraps to 0 on overflow.
  - CycleCnt: +1 every RUN edge, including the halting syscall edge.
  - JumpCnt: +1 when JMP|JAL|JR.
  - BranchCnt: +1 when Taken and no higher-priority jump.
- Undefined: counter logic is removed and CycleCnt, JumpCnt, BranchCnt are tied to 0.

Test Plan:
- Reset/sequential: RESET_PC=0, release RST_N, no strobes for 3 edges -> PC=0,4,8,12; Halted=0; CycleCnt=3.
- Branches: PC=0x10, Beq=1, Equal=1, Instr[15:0]=0xFFFC -> PC=0x04, BranchCnt+1. Repeat with Equal=0 -> PC=0x14, BranchCnt unchanged. BLTZ with RsData=0x8000_0000 -> branch taken.
- Jumps: PC=0x3000_0040, JAL, Instr[25:0]=0x0000100 -> PC=0x3000_0400, PCPlus4 was 0x3000_0044 on the JAL cycle. JR+JMP together with RsData=0x200 -> PC=0x200, JumpCnt+1 once.
- Syscall display/halt: V0=34, A0=0xDEAD_BEEF, SysCALL -> LedData=0xDEADBEEF, still RUN. V0=10, SysCALL at PC=0x20 -> Halted=1, PC=0x24, counters frozen for 5 idle edges. Go=1 -> Halted=0, next edge PC=0x28.
- Async reset mid-halt: in HALT with CycleCnt=57, pulse RST_N low between edges -> PC, LedData and counters read 0 and Halted=0 immediately, before the next edge.
- Counter wrap (STATS_EN, CNT_WIDTH=4): 16 RUN edges -> CycleCnt wraps to 0. Build without the macro -> all counters read 0 throughout.
